// File: rtl/mux2_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mux2_rr_arbiter_if
// Purpose  : Bundles the two requester ports and the output port of the
//            2:1 round-robin arbiter.
// Ports    : in0_valid/in0_data/in0_ready  - requester 0 handshake
//            in1_valid/in1_data/in1_ready  - requester 1 handshake
//            out_valid/out_data/out_sel/out_ready - registered output beat
// Modports : slave  - arbiter side (consumes requests, drives output)
//            master - environment side (producers plus downstream sink)
// Revision : 1.0 - initial release
// ============================================================================
interface mux2_rr_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              in0_valid;
  logic [DATA_W-1:0] in0_data;
  logic              in0_ready;
  logic              in1_valid;
  logic [DATA_W-1:0] in1_data;
  logic              in1_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_sel;
  logic              out_ready;

  modport slave (
    input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
    output in0_ready, in1_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in0_valid, in0_data, in1_valid, in1_data, out_ready,
    input  in0_ready, in1_ready, out_valid, out_data, out_sel
  );
endinterface
`default_nettype wire

// File: rtl/mux2_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux2_rr_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing a 2:1 mux between two
//            valid/ready requesters, with a registered output stage and a
//            bounded burst length so neither requester starves the other.
// Ports    : clk  - system clock
//            rst  - synchronous reset, active-high
//            bus  - mux2_rr_arbiter_if.slave (requesters + output beat)
//            gnt0_cnt/gnt1_cnt - accepted-beat counters per port, mod 256
//                                (present only with MUX2_RR_ARBITER_STATS_EN)
// Options  : MUX2_RR_ARBITER_STATS_EN - adds the per-port beat counters
// Revision : 1.0 - initial release
// ============================================================================
module mux2_rr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  wire logic            clk,
  input  wire logic            rst,
  mux2_rr_arbiter_if.slave     bus
`ifdef MUX2_RR_ARBITER_STATS_EN
  ,
  output logic [7:0]           gnt0_cnt,
  output logic [7:0]           gnt1_cnt
`endif
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_GNT0 = 2'd1;
  localparam logic [1:0] c_ST_GNT1 = 2'd2;
  localparam logic [3:0] c_MAX     = 4'(MAX_BURST);

  logic [1:0]        r_state, w_state_nxt;
  logic              r_last_grant, w_last_grant_nxt;
  logic [3:0]        r_burst_cnt, w_burst_cnt_nxt, w_cnt_inc;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_sel;
  logic              w_out_free;
  logic              w_ready0, w_ready1;
  logic              w_acc0, w_acc1, w_accept;
  logic              w_own_valid, w_oth_valid;

  // Output stage can take a new beat when empty or being drained this cycle.
  assign w_out_free = !r_out_valid || bus.out_ready;
  assign w_acc0     = bus.in0_valid && w_ready0;
  assign w_acc1     = bus.in1_valid && w_ready1;
  assign w_accept   = w_acc0 || w_acc1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_ST_IDLE;
      r_last_grant <= 1'b1;       // port 0 wins the first tie
      r_burst_cnt  <= 4'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_burst_cnt  <= w_burst_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_burst_cnt_nxt  = r_burst_cnt;
    w_own_valid      = (r_state == c_ST_GNT1) ? bus.in1_valid : bus.in0_valid;
    w_oth_valid      = (r_state == c_ST_GNT1) ? bus.in0_valid : bus.in1_valid;
    // Saturate so a lone requester can stream forever; the switch then
    // happens on its first accept after the other port starts requesting.
    w_cnt_inc        = r_burst_cnt;
    if (w_accept && (r_burst_cnt != c_MAX)) begin
      w_cnt_inc = r_burst_cnt + 4'd1;
    end

    case (r_state)
      c_ST_IDLE: begin
        if (bus.in0_valid && bus.in1_valid) begin
          w_state_nxt = r_last_grant ? c_ST_GNT0 : c_ST_GNT1;
        end else if (bus.in0_valid) begin
          w_state_nxt = c_ST_GNT0;
        end else if (bus.in1_valid) begin
          w_state_nxt = c_ST_GNT1;
        end
      end
      c_ST_GNT0, c_ST_GNT1: begin
        // Everything is frozen while the output stage is stalled.
        if (w_out_free) begin
          if ((w_accept && (w_cnt_inc == c_MAX) && w_oth_valid) ||
              (!w_own_valid && w_oth_valid)) begin
            w_state_nxt      = (r_state == c_ST_GNT0) ? c_ST_GNT1 : c_ST_GNT0;
            w_burst_cnt_nxt  = 4'd0;
            w_last_grant_nxt = (r_state == c_ST_GNT1);
          end else if (!w_own_valid && !w_oth_valid) begin
            w_state_nxt      = c_ST_IDLE;
            w_burst_cnt_nxt  = 4'd0;
            w_last_grant_nxt = (r_state == c_ST_GNT1);
          end else begin
            w_burst_cnt_nxt  = w_cnt_inc;
          end
        end
      end
      default: begin
        w_state_nxt     = c_ST_IDLE;
        w_burst_cnt_nxt = 4'd0;
      end
    endcase
  end

  // Output decode: ready depends only on registers and out_ready.
  always_comb begin
    w_ready0 = (r_state == c_ST_GNT0) && w_out_free;
    w_ready1 = (r_state == c_ST_GNT1) && w_out_free;
  end

  // Registered output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_acc1 ? bus.in1_data : bus.in0_data;
      r_out_sel   <= w_acc1;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in0_ready = w_ready0;
  assign bus.in1_ready = w_ready1;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sel   = r_out_sel;

`ifdef MUX2_RR_ARBITER_STATS_EN
  logic [7:0] r_gnt0_cnt, r_gnt1_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt0_cnt <= 8'd0;
      r_gnt1_cnt <= 8'd0;
    end else begin
      if (w_acc0) r_gnt0_cnt <= r_gnt0_cnt + 8'd1;
      if (w_acc1) r_gnt1_cnt <= r_gnt1_cnt + 8'd1;
    end
  end

  assign gnt0_cnt = r_gnt0_cnt;
  assign gnt1_cnt = r_gnt1_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux2_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux2_rr_arbiter
// Purpose  : Directed, table-driven bench for mux2_rr_arbiter (DATA_W=8,
//            MAX_BURST=4). Each row gives the inputs applied for one cycle,
//            the expected ready outputs for that cycle and the expected
//            registered output as left by the previous clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux2_rr_arbiter;

  typedef struct {
    bit       rst;
    bit       i0v;
    bit [7:0] d0;
    bit       i1v;
    bit [7:0] d1;
    bit       ordy;
    bit       e_r0;
    bit       e_r1;
    bit       e_ov;
    bit [7:0] e_od;
    bit       e_os;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mux2_rr_arbiter_if #(.DATA_W(8)) bus ();

`ifdef MUX2_RR_ARBITER_STATS_EN
  logic [7:0] gnt0_cnt, gnt1_cnt;
  mux2_rr_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt)
  );
`else
  mux2_rr_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
`endif

  function automatic vec_t mk(input bit r, input bit i0v, input bit [7:0] d0,
                              input bit i1v, input bit [7:0] d1, input bit ordy,
                              input bit e_r0, input bit e_r1, input bit e_ov,
                              input bit [7:0] e_od, input bit e_os);
    vec_t v;
    v.rst = r; v.i0v = i0v; v.d0 = d0; v.i1v = i1v; v.d1 = d1; v.ordy = ordy;
    v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_ov = e_ov; v.e_od = e_od; v.e_os = e_os;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst           = v.rst;
    bus.in0_valid = v.i0v;
    bus.in0_data  = v.d0;
    bus.in1_valid = v.i1v;
    bus.in1_data  = v.d1;
    bus.out_ready = v.ordy;
  endtask

  initial begin
    bit found;
    int waits;

    //           rst i0v d0     i1v d1     ordy r0 r1 ov od     os
    // reset, then idle
    vecs.push_back(mk(1, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0)); // 0
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0));
    // single port 0: IDLE bubble then one beat per cycle
    vecs.push_back(mk(0, 1, 8'h11, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0)); // 3
    vecs.push_back(mk(0, 1, 8'h11, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 8'h22, 0, 8'h00, 1, 1, 0, 1, 8'h11, 0));
    vecs.push_back(mk(0, 1, 8'h33, 0, 8'h00, 1, 1, 0, 1, 8'h22, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 1, 0, 1, 8'h33, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0)); // 8
    // fairness after a fresh reset: 4 from port 0, 4 from port 1, no bubble
    vecs.push_back(mk(1, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0)); // 9
    vecs.push_back(mk(0, 1, 8'hA0, 1, 8'hB0, 1, 0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 8'hA0, 1, 8'hB0, 1, 1, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 8'hA1, 1, 8'hB0, 1, 1, 0, 1, 8'hA0, 0));
    vecs.push_back(mk(0, 1, 8'hA2, 1, 8'hB0, 1, 1, 0, 1, 8'hA1, 0));
    vecs.push_back(mk(0, 1, 8'hA3, 1, 8'hB0, 1, 1, 0, 1, 8'hA2, 0)); // 14
    vecs.push_back(mk(0, 1, 8'hA4, 1, 8'hB0, 1, 0, 1, 1, 8'hA3, 0));
    vecs.push_back(mk(0, 1, 8'hA4, 1, 8'hB1, 1, 0, 1, 1, 8'hB0, 1));
    vecs.push_back(mk(0, 1, 8'hA4, 1, 8'hB2, 1, 0, 1, 1, 8'hB1, 1));
    vecs.push_back(mk(0, 1, 8'hA4, 1, 8'hB3, 1, 0, 1, 1, 8'hB2, 1)); // 18
    vecs.push_back(mk(0, 1, 8'hA4, 1, 8'hB4, 1, 1, 0, 1, 8'hB3, 1));
    vecs.push_back(mk(0, 1, 8'hA5, 1, 8'hB4, 1, 1, 0, 1, 8'hA4, 0));
    // backpressure: 0xA5 held for 5 cycles, nothing accepted
    vecs.push_back(mk(0, 1, 8'hA6, 1, 8'hB4, 0, 0, 0, 1, 8'hA5, 0)); // 21
    vecs.push_back(mk(0, 1, 8'hA6, 1, 8'hB4, 0, 0, 0, 1, 8'hA5, 0));
    vecs.push_back(mk(0, 1, 8'hA6, 1, 8'hB4, 0, 0, 0, 1, 8'hA5, 0));
    vecs.push_back(mk(0, 1, 8'hA6, 1, 8'hB4, 0, 0, 0, 1, 8'hA5, 0));
    vecs.push_back(mk(0, 1, 8'hA6, 1, 8'hB4, 0, 0, 0, 1, 8'hA5, 0));
    // release: 0xA5 drains and A6 accepted the same cycle; count resumes at 3
    vecs.push_back(mk(0, 1, 8'hA6, 1, 8'hB4, 1, 1, 0, 1, 8'hA5, 0)); // 26
    vecs.push_back(mk(0, 1, 8'hA7, 1, 8'hB4, 1, 1, 0, 1, 8'hA6, 0));
    // early release: port 1 sends 2 beats, drops valid, port 0 takes over
    vecs.push_back(mk(0, 1, 8'hA8, 1, 8'hB4, 1, 0, 1, 1, 8'hA7, 0)); // 28
    vecs.push_back(mk(0, 1, 8'hA8, 1, 8'hB5, 1, 0, 1, 1, 8'hB4, 1));
    vecs.push_back(mk(0, 1, 8'hA8, 0, 8'h00, 1, 0, 1, 1, 8'hB5, 1));
    vecs.push_back(mk(0, 1, 8'hA8, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0)); // 31
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 1, 0, 1, 8'hA8, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0));
    // tie with last_grant=0 goes to port 1
    vecs.push_back(mk(0, 1, 8'hA9, 1, 8'hB6, 1, 0, 0, 0, 8'h00, 0)); // 34
    vecs.push_back(mk(0, 1, 8'hA9, 1, 8'hB6, 1, 0, 1, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 8'hA9, 1, 8'hB7, 1, 0, 1, 1, 8'hB6, 1));
    // mid-burst reset after the 2nd beat; next tie goes to port 0
    vecs.push_back(mk(1, 1, 8'hA9, 1, 8'hB8, 1, 0, 1, 1, 8'hB7, 1)); // 37
    vecs.push_back(mk(0, 1, 8'hA9, 1, 8'hB8, 1, 0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 8'hA9, 1, 8'hB8, 1, 1, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 1, 0, 1, 8'hA9, 0)); // 40
    // saturation: lone port 0 streams past MAX_BURST, switch on next accept
    vecs.push_back(mk(0, 1, 8'hC0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0)); // 41
    vecs.push_back(mk(0, 1, 8'hC0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 8'hC1, 0, 8'h00, 1, 1, 0, 1, 8'hC0, 0));
    vecs.push_back(mk(0, 1, 8'hC2, 0, 8'h00, 1, 1, 0, 1, 8'hC1, 0));
    vecs.push_back(mk(0, 1, 8'hC3, 0, 8'h00, 1, 1, 0, 1, 8'hC2, 0));
    vecs.push_back(mk(0, 1, 8'hC4, 0, 8'h00, 1, 1, 0, 1, 8'hC3, 0)); // 46
    vecs.push_back(mk(0, 1, 8'hC5, 1, 8'hD0, 1, 1, 0, 1, 8'hC4, 0));
    vecs.push_back(mk(0, 1, 8'hC6, 1, 8'hD0, 1, 0, 1, 1, 8'hC5, 0));
    vecs.push_back(mk(0, 1, 8'hC6, 0, 8'h00, 1, 0, 1, 1, 8'hD0, 1));
    vecs.push_back(mk(0, 1, 8'hC6, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0)); // 50
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 1, 0, 1, 8'hC6, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0));

    bus.in0_valid = 1'b0; bus.in0_data = 8'h00;
    bus.in1_valid = 1'b0; bus.in1_data = 8'h00;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      n_vec++;
      if (bus.in0_ready !== vecs[i].e_r0 || bus.in1_ready !== vecs[i].e_r1 ||
          bus.out_valid !== vecs[i].e_ov ||
          (vecs[i].e_ov && (bus.out_data !== vecs[i].e_od ||
                            bus.out_sel !== vecs[i].e_os))) begin
        n_err++;
        $display("FAIL vec%0d: got r0=%b r1=%b ov=%b od=%h os=%b, expected r0=%b r1=%b ov=%b od=%h os=%b",
                 i, bus.in0_ready, bus.in1_ready, bus.out_valid, bus.out_data, bus.out_sel,
                 vecs[i].e_r0, vecs[i].e_r1, vecs[i].e_ov, vecs[i].e_od, vecs[i].e_os);
      end
    end

    // Hand sequence: bounded wait for a lone port-1 grant after reset;
    // exactly one arbitration bubble is expected.
    @(negedge clk);
    rst = 1'b1; bus.in0_valid = 1'b0; bus.in1_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.in1_valid = 1'b1; bus.in1_data = 8'hE0;
    found = 1'b0;
    waits = 0;
    for (int k = 0; k < 4 && !found; k++) begin
      #1;
      if (bus.in1_ready === 1'b1) found = 1'b1;
      else begin
        waits++;
        @(negedge clk);
      end
    end
    n_vec++;
    if (!found || waits != 1) begin
      n_err++;
      $display("FAIL grant_latency: got found=%b waits=%0d, expected found=1 waits=1", found, waits);
    end
    @(negedge clk);
    bus.in1_valid = 1'b0;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hE0 || bus.out_sel !== 1'b1) begin
      n_err++;
      $display("FAIL port1_beat: got ov=%b od=%h os=%b, expected ov=1 od=e0 os=1",
               bus.out_valid, bus.out_data, bus.out_sel);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
